// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings for the mult/div sequencer: FSM states, operation codes
// and Hi/Lo source-select values used by control_unit and the sequencer.
package muldiv_sequencer_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_FIN   = 3'd4;
  localparam logic [2:0] ST_EXC   = 3'd5;
  localparam logic [2:0] ST_TOUT  = 3'd6;

  localparam logic OP_MULT  = 1'b0;
  localparam logic OP_DIV   = 1'b1;
  localparam logic SEL_DIV  = 1'b0;
  localparam logic SEL_MULT = 1'b1;

  // Hi/Lo mux select that routes the result of the given operation.
  function automatic logic op_to_sel(input logic op);
    return (op == OP_DIV) ? SEL_DIV : SEL_MULT;
  endfunction

endpackage

// File: rtl/muldiv_wait_ctr.sv
// Cycle counter for the WAIT state: clear, enable and a terminal flag that
// marks the last cycle allowed before the unit is declared hung.
module muldiv_wait_ctr #(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign terminal = (cnt_q == CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences one MULT or DIV request through the shared units and owns the
// Hi/Lo write timing; every output except the select muxes is registered.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic op_div,
  input  logic abort,
  input  logic div_zero,
  input  logic mult_done,
  input  logic div_done,
  output logic mult_start,
  output logic div_start,
  output logic sel_mux_hi,
  output logic sel_mux_lo,
  output logic HiLo_load,
  output logic busy,
  output logic done,
  output logic div_zero_exc,
  output logic timeout_err
);

  logic [2:0] state_q, state_d;
  logic       op_q, op_d;
  logic       mult_start_q, mult_start_d;
  logic       div_start_q, div_start_d;
  logic       hilo_load_q, hilo_load_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       div_zero_exc_q, div_zero_exc_d;
  logic       timeout_err_q, timeout_err_d;
  logic       unit_done;
  logic       wait_terminal;

  muldiv_wait_ctr #(
    .MAX_WAIT(MAX_WAIT),
    .CNT_W   (CNT_W)
  ) u_wait_ctr (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q == ST_ISSUE),
    .enable  (state_q == ST_WAIT),
    .terminal(wait_terminal)
  );

  // Only the done of the unit we started counts; the other unit is ignored.
  assign unit_done = (op_q == OP_DIV) ? div_done : mult_done;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ISSUE;
          op_d    = op_div;
        end
      end
      ST_ISSUE: begin
        if ((op_q == OP_DIV) && div_zero) begin
          state_d = ST_EXC;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (unit_done) begin
          state_d = ST_WRITE;
        end else if (wait_terminal) begin
          state_d = ST_TOUT;
        end
      end
      ST_WRITE: state_d = ST_FIN;
      default:  state_d = ST_IDLE;
    endcase
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end
  end

  // Pulses are registered from the next state so each lines up with its state.
  always_comb begin
    busy_d         = (state_d != ST_IDLE);
    hilo_load_d    = (state_d == ST_WRITE);
    done_d         = (state_d == ST_FIN);
    div_zero_exc_d = (state_d == ST_EXC);
    timeout_err_d  = (state_d == ST_TOUT);
    mult_start_d   = (state_q == ST_ISSUE) && (state_d == ST_WAIT) && (op_q == OP_MULT);
    div_start_d    = (state_q == ST_ISSUE) && (state_d == ST_WAIT) && (op_q == OP_DIV);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      op_q           <= OP_MULT;
      mult_start_q   <= 1'b0;
      div_start_q    <= 1'b0;
      hilo_load_q    <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      div_zero_exc_q <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      mult_start_q   <= mult_start_d;
      div_start_q    <= div_start_d;
      hilo_load_q    <= hilo_load_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      div_zero_exc_q <= div_zero_exc_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign sel_mux_hi   = (state_q == ST_IDLE) ? 1'b0 : op_to_sel(op_q);
  assign sel_mux_lo   = (state_q == ST_IDLE) ? 1'b0 : op_to_sel(op_q);
  assign mult_start   = mult_start_q;
  assign div_start    = div_start_q;
  assign HiLo_load    = hilo_load_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign div_zero_exc = div_zero_exc_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized bench for muldiv_sequencer: each transaction is a plan whose
// expected output timeline is derived arithmetically and checked every cycle.
module tb_muldiv_sequencer;

  localparam int MAX_WAIT = 64;

  logic clk = 1'b0;
  logic reset, start, op_div, abort, div_zero, mult_done, div_done;
  logic mult_start, div_start, sel_mux_hi, sel_mux_lo, HiLo_load;
  logic busy, done, div_zero_exc, timeout_err;

  // Relative cycle r = the clock period following edge r; start is driven in r=0.
  typedef struct {
    logic op;
    logic dz;
    int   done_at;
    int   abort_at;
    int   rst_at;
  } plan_t;

  typedef struct {
    logic busy;
    logic mult_start;
    logic div_start;
    logic sel;
    logic hilo;
    logic done;
    logic exc;
    logic tout;
  } exp_t;

  exp_t  exp_cur;
  exp_t  exp_zero;
  bit    chk_en;
  int    checks;
  int    errors;
  int    cyc_r;
  string tag;

  always #5 clk = ~clk;

  muldiv_sequencer #(.MAX_WAIT(MAX_WAIT), .CNT_W(7)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op_div      (op_div),
    .abort       (abort),
    .div_zero    (div_zero),
    .mult_done   (mult_done),
    .div_done    (div_done),
    .mult_start  (mult_start),
    .div_start   (div_start),
    .sel_mux_hi  (sel_mux_hi),
    .sel_mux_lo  (sel_mux_lo),
    .HiLo_load   (HiLo_load),
    .busy        (busy),
    .done        (done),
    .div_zero_exc(div_zero_exc),
    .timeout_err (timeout_err)
  );

  // First relative cycle in which the sequencer is back in IDLE.
  function automatic int plan_end(input plan_t p);
    int fin;
    if (p.op && p.dz)        fin = 3;
    else if (p.done_at >= 0) fin = p.done_at + 3;
    else                     fin = MAX_WAIT + 3;
    if (p.abort_at >= 1 && p.abort_at + 1 < fin) fin = p.abort_at + 1;
    if (p.rst_at >= 1 && p.rst_at + 1 < fin)     fin = p.rst_at + 1;
    return fin;
  endfunction

  function automatic exp_t model(input plan_t p, input int r);
    exp_t e;
    int   fin;
    logic zexc;
    e    = '{default: 1'b0};
    fin  = plan_end(p);
    zexc = p.op && p.dz;
    if (r >= 1 && r < fin) begin
      e.busy       = 1'b1;
      e.sel        = ~p.op;
      e.mult_start = (r == 2) && !p.op;
      e.div_start  = (r == 2) && p.op && !p.dz;
      e.exc        = zexc && (r == 2);
      e.hilo       = !zexc && (p.done_at >= 0) && (r == p.done_at + 1);
      e.done       = !zexc && (p.done_at >= 0) && (r == p.done_at + 2);
      e.tout       = !zexc && (p.done_at < 0) && (r == MAX_WAIT + 2);
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s (%s r=%0d): got %0b want %0b", name, tag, cyc_r, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("busy",         busy,         exp_cur.busy);
      checkOutput("mult_start",   mult_start,   exp_cur.mult_start);
      checkOutput("div_start",    div_start,    exp_cur.div_start);
      checkOutput("sel_mux_hi",   sel_mux_hi,   exp_cur.sel);
      checkOutput("sel_mux_lo",   sel_mux_lo,   exp_cur.sel);
      checkOutput("HiLo_load",    HiLo_load,    exp_cur.hilo);
      checkOutput("done",         done,         exp_cur.done);
      checkOutput("div_zero_exc", div_zero_exc, exp_cur.exc);
      checkOutput("timeout_err",  timeout_err,  exp_cur.tout);
    end
  end

  // Drives one transaction, with noise on every input the plan says must be ignored.
  task automatic applyStimulus(input plan_t p, input string name);
    int   fin;
    logic own, other;
    fin = plan_end(p);
    tag = name;
    for (int r = 0; r < fin; r++) begin
      cyc_r    = r;
      start    = (r == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
      op_div   = (r == 0) ? p.op : 1'($urandom_range(0, 1));
      div_zero = (r == 1) ? p.dz : 1'($urandom_range(0, 1));
      abort    = (r == p.abort_at) || ((r == 0) && ($urandom_range(0, 3) == 0));
      reset    = (r == p.rst_at);
      own      = (r == p.done_at) ||
                 (((r == 1) || ((p.done_at >= 0) && (r > p.done_at))) && ($urandom_range(0, 2) == 0));
      other    = ($urandom_range(0, 3) == 0);
      div_done  = p.op ? own : other;
      mult_done = p.op ? other : own;
      exp_cur  = model(p, r);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic runIdle(input int n, input logic late_done);
    tag = late_done ? "idle_late_done" : "idle";
    for (int i = 0; i < n; i++) begin
      cyc_r     = i;
      start     = 1'b0;
      reset     = 1'b0;
      op_div    = 1'($urandom_range(0, 1));
      div_zero  = 1'($urandom_range(0, 1));
      abort     = 1'($urandom_range(0, 1));
      mult_done = late_done ? 1'b1 : 1'($urandom_range(0, 1));
      div_done  = 1'($urandom_range(0, 1));
      exp_cur   = exp_zero;
      @(posedge clk);
      #1;
    end
  endtask

  function automatic plan_t mk(input logic op, input logic dz, input int done_at,
                               input int abort_at, input int rst_at);
    plan_t p;
    p.op = op; p.dz = dz; p.done_at = done_at; p.abort_at = abort_at; p.rst_at = rst_at;
    return p;
  endfunction

  initial begin
    plan_t p;
    exp_t  e;
    checks   = 0;
    errors   = 0;
    chk_en   = 1'b0;
    exp_zero = '{default: 1'b0};
    exp_cur  = exp_zero;
    reset = 1'b1; start = 1'b0; op_div = 1'b0; abort = 1'b0;
    div_zero = 1'b0; mult_done = 1'b0; div_done = 1'b0;

    // Hand-computed timeline points that pin the model itself.
    tag = "pin";
    p = mk(1'b0, 1'b0, 35, -1, -1);
    e = model(p, 2);  cyc_r = 2;  checkOutput("pin_mult_start", e.mult_start, 1'b1);
    e = model(p, 36); cyc_r = 36; checkOutput("pin_hilo",       e.hilo,       1'b1);
    e = model(p, 37); cyc_r = 37; checkOutput("pin_done",       e.done,       1'b1);
    e = model(p, 38); cyc_r = 38; checkOutput("pin_busy_low",   e.busy,       1'b0);
    p = mk(1'b0, 1'b0, -1, -1, -1);
    e = model(p, 65); cyc_r = 65; checkOutput("pin_no_tout",    e.tout,       1'b0);
    e = model(p, 66); cyc_r = 66; checkOutput("pin_tout",       e.tout,       1'b1);
    p = mk(1'b1, 1'b1, -1, -1, -1);
    e = model(p, 2);  cyc_r = 2;  checkOutput("pin_exc",        e.exc,        1'b1);
    checkOutput("pin_no_div_start", e.div_start, 1'b0);

    @(posedge clk);
    #1;
    tag    = "reset";
    cyc_r  = 0;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    runIdle(2, 1'b0);

    applyStimulus(mk(1'b0, 1'b0, 35, -1, -1), "mult");
    applyStimulus(mk(1'b1, 1'b0, 34, -1, -1), "div");
    applyStimulus(mk(1'b1, 1'b1, -1, -1, -1), "div_zero");
    applyStimulus(mk(1'b0, 1'b0, -1, -1, -1), "timeout");
    applyStimulus(mk(1'b0, 1'b0, MAX_WAIT + 1, -1, -1), "done_on_last_count");
    applyStimulus(mk(1'b1, 1'b0, 2, -1, -1), "div_fast");
    applyStimulus(mk(1'b0, 1'b0, 30, 12, -1), "abort_wait");
    runIdle(1, 1'b1);
    applyStimulus(mk(1'b0, 1'b0, 8, 5, -1), "abort_back_to_back");
    applyStimulus(mk(1'b1, 1'b0, 6, -1, -1), "start_after_abort");
    applyStimulus(mk(1'b0, 1'b0, 20, -1, 21), "reset_in_write");
    applyStimulus(mk(1'b1, 1'b0, 10, 1, -1), "abort_issue");
    applyStimulus(mk(1'b1, 1'b1, -1, 2, -1), "abort_exc");
    applyStimulus(mk(1'b0, 1'b0, 5, 7, -1), "abort_fin");
    applyStimulus(mk(1'b1, 1'b0, 9, 9, -1), "abort_with_done");

    for (int t = 0; t < 40; t++) begin
      p.op       = 1'($urandom_range(0, 1));
      p.dz       = p.op && ($urandom_range(0, 3) == 0);
      p.done_at  = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(2, MAX_WAIT + 1));
      p.abort_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 40)) : -1;
      p.rst_at   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 40)) : -1;
      applyStimulus(p, "random");
      runIdle(int'($urandom_range(0, 2)), 1'b0);
    end

    runIdle(2, 1'b0);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
